bicubic_symmertial_demux: RTL and testbench
===========================================

// Module: bicubic_symmertial_demux
// PURPOSE
//  Output-side counterpart of the Y-symmetric input mux. Takes one 4x4 output superblock
//  per beat as two 8-lane DSP group result buses (low/high) and undoes the Y mirroring.
//  Buffers up to DEPTH superblocks and streams them out row by row (4 px/row, row 0 first)
//  over a valid/ready handshake toward the output line writer.
// PARAMETERS
//  PIX_W   8   bits per pixel lane
//  DEPTH   2   superblock buffer entries; power of 2, >= 2 (2 = ping-pong)
// PORTS
//  clk                input   1         system clock, all state on rising edge
//  aresetn            input   1         asynchronous active-low reset
//  clken              input   1         clock enable (only with BICUBIC_DEMUX_CLKEN_EN)
//  in_valid           input   1         superblock beat valid
//  in_ready           output  1         buffer can accept a beat
//  super_y_symmetric  input   1         beat was computed in mirrored-line order
//  dsp_grp_l_in       input   8*PIX_W   low group results; lane k = bits [PIX_W*k +: PIX_W]
//  dsp_grp_h_in       input   8*PIX_W   high group results, same lane layout
//  out_valid          output  1         out_row valid
//  out_ready          input   1         downstream accepts row
//  out_row            output  4*PIX_W   one output row; pixel x at [PIX_W*x +: PIX_W]
//  out_row_idx        output  2         row index 0..3 within the superblock
//  out_last           output  1         high with row 3 (end of superblock)
// BEHAVIOUR
//  - Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready (rising edge).
//    in_valid/out_valid never depend combinationally on the ready inputs.
//  - Lane map, super_y_symmetric=0: l lanes 0-3 -> row0 x0-3, l 4-7 -> row1,
//    h 0-3 -> row2, h 4-7 -> row3.
//  - super_y_symmetric=1: l 0-3 -> row3, l 4-7 -> row2, h 0-3 -> row1, h 4-7 -> row0.
//    Row is mirrored, x order within a row is kept.
//  - super_y_symmetric is sampled together with the data on push only.
//  - Storage: DEPTH entries of 16 px each, stored already de-mirrored.
//    wr_ptr, rd_ptr wrap modulo DEPTH. count is 0..DEPTH. row_ptr is 0..3.
//  - in_ready = (count != DEPTH), combinational from registered count. No bypass when full.
//  - out_valid = (count != 0). out_row = entry[rd_ptr].row[row_ptr].
//    out_row_idx = row_ptr. out_last = (row_ptr == 3).
//  - Pop with row_ptr<3: row_ptr+1. Pop with row_ptr==3: row_ptr->0, rd_ptr+1, count-1.
//  - Latency: beat pushed at edge N into empty buffer -> out_valid, row 0 visible after N.
//    Minimum 4 cycles per superblock at the output.
//  - Simultaneous push and last-row pop: count unchanged; both pointers advance.
//    Allowed at any count < DEPTH. At count==DEPTH only the pop occurs.
//  - out_ready low holds out_row/out_row_idx/out_last stable while out_valid is high.
//  - Reset (any time, incl. mid-superblock): count=0, wr_ptr=rd_ptr=row_ptr=0,
//    storage cleared to 0. Partial superblock is discarded.
//    Outputs after reset: out_valid=0, out_row=0, out_row_idx=0, out_last=0, in_ready=1.
// CONFIGURATION
//  - BICUBIC_DEMUX_CLKEN_EN defined: clken port present.
//    clken=0 freezes all state and forces in_ready=0 and out_valid=0,
//    so no handshake completes. Data outputs hold their value.
//  - Not defined: no clken port; block always enabled.
// TESTING
//  - Reset then idle: in_ready=1, out_valid=0, out_row=0, out_row_idx=0, out_last=0.
//  - Normal order, sym=0, l lanes = 0x00..0x07, h lanes = 0x08..0x0F, out_ready=1:
//    rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on idx 0-3; last on row 3.
//  - Same data with sym=1:
//    rows 0x0F0E0D0C, 0x0B0A0908, 0x07060504, 0x03020100.
//  - out_ready=0, push 3 beats (DEPTH=2): beats 1-2 accepted, in_ready=0 on beat 3.
//    Row 0 of beat 1 held stable.
//  - Continuous push with out_ready=1: push coincides with each row-3 pop.
//    Throughput 1 SB / 4 cycles, no beat lost or reordered.
//  - aresetn pulsed after row 1 popped: outputs return to reset values.
//    Next beat emits from row 0. With _CLKEN_EN: clken=0 for 3 cycles freezes row_ptr.

Source files
------------

// File: rtl/bicubic_symmertial_demux.sv
// bicubic_symmertial_demux
//   Output-side counterpart of the Y-symmetric input mux. Each accepted beat carries one
//   4x4 superblock as two 8-lane result buses (low/high). The beat is de-mirrored when
//   super_y_symmetric is set, stored in a DEPTH-entry buffer, and streamed out one
//   4-pixel row per handshake, row 0 first.
//
// Parameters
//   PIX_W  bits per pixel lane
//   DEPTH  superblock buffer entries (power of 2, >= 2)
//
// Ports
//   clk, aresetn                 clock, asynchronous active-low reset
//   clken                        clock enable (present only with BICUBIC_DEMUX_CLKEN_EN)
//   in_valid / in_ready          superblock beat handshake
//   super_y_symmetric            beat lanes are in mirrored-row order
//   dsp_grp_l_in, dsp_grp_h_in   low/high group results, lane k at [PIX_W*k +: PIX_W]
//   out_valid / out_ready        row handshake
//   out_row                      4 pixels, pixel x at [PIX_W*x +: PIX_W]
//   out_row_idx, out_last        row index within the superblock, high on row 3
//
// Optional feature macro: BICUBIC_DEMUX_CLKEN_EN (adds the clken port; clken=0 freezes
// all state and blocks both handshakes).
module bicubic_symmertial_demux #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               aresetn,
`ifdef BICUBIC_DEMUX_CLKEN_EN
  input  logic               clken,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               super_y_symmetric,
  input  logic [8*PIX_W-1:0] dsp_grp_l_in,
  input  logic [8*PIX_W-1:0] dsp_grp_h_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*PIX_W-1:0] out_row,
  output logic [1:0]         out_row_idx,
  output logic               out_last
);

  localparam int ROW_W = 4 * PIX_W;
  localparam int SB_W  = 16 * PIX_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entries are kept in natural row order: row r at [ROW_W*r +: ROW_W].
  function automatic logic [SB_W-1:0] demirror(input logic [2*ROW_W-1:0] l,
                                               input logic [2*ROW_W-1:0] h,
                                               input logic               sym);
    if (!sym) return {h, l};
    return {l[ROW_W-1:0], l[2*ROW_W-1:ROW_W], h[ROW_W-1:0], h[2*ROW_W-1:ROW_W]};
  endfunction

  logic [SB_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       row_ptr;
  logic [SB_W-1:0]  rd_entry;
  logic             en;
  logic             push;
  logic             pop;
  logic             last_pop;

`ifdef BICUBIC_DEMUX_CLKEN_EN
  assign en = clken;
`else
  assign en = 1'b1;
`endif

  // Readiness comes from registered count only, so neither valid depends on a ready.
  assign in_ready  = en && (count != CNT_W'(DEPTH));
  assign out_valid = en && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (row_ptr == 2'd3);

  assign rd_entry    = mem[rd_ptr];
  assign out_row_idx = row_ptr;
  assign out_last    = (row_ptr == 2'd3);

  always_comb begin
    out_row = '0;
    case (row_ptr)
      2'd0:    out_row = rd_entry[0*ROW_W +: ROW_W];
      2'd1:    out_row = rd_entry[1*ROW_W +: ROW_W];
      2'd2:    out_row = rd_entry[2*ROW_W +: ROW_W];
      default: out_row = rd_entry[3*ROW_W +: ROW_W];
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      row_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      if (push) begin
        mem[wr_ptr] <= demirror(dsp_grp_l_in, dsp_grp_h_in, super_y_symmetric);
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        row_ptr <= row_ptr + 2'd1;
        if (last_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, last_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_symmertial_demux.sv
module tb_bicubic_symmertial_demux;

  localparam int PIX_W = 8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        clken = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        super_y_symmetric = 1'b0;
  logic [63:0] dsp_grp_l_in = '0;
  logic [63:0] dsp_grp_h_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_row;
  logic [1:0]  out_row_idx;
  logic        out_last;

  int checks = 0;
  int failures = 0;

  // Reference: rows still to be emitted, in emission order.
  logic [31:0] rowq[$];

  always #5 clk = ~clk;

  bicubic_symmertial_demux #(.PIX_W(PIX_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .aresetn(aresetn),
`ifdef BICUBIC_DEMUX_CLKEN_EN
    .clken(clken),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .super_y_symmetric(super_y_symmetric),
    .dsp_grp_l_in(dsp_grp_l_in),
    .dsp_grp_h_in(dsp_grp_h_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row(out_row),
    .out_row_idx(out_row_idx),
    .out_last(out_last)
  );

  // Lane k of {h,l} (0..15) naturally belongs to row k/4, pixel k%4; mirroring flips the row.
  function automatic logic [31:0] exp_row(input logic [63:0] l, input logic [63:0] h,
                                          input logic sym, input int r);
    logic [31:0] res;
    logic [7:0]  pix;
    int          nat;
    int          row;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      pix = (k < 8) ? l[8*k +: 8] : h[8*(k-8) +: 8];
      nat = k / 4;
      row = sym ? 3 - nat : nat;
      if (row == r) res[8*(k%4) +: 8] = pix;
    end
    return res;
  endfunction

  // Compare visible outputs with the reference, then advance one clock.
  task automatic step();
    int          sz;
    int          cnt;
    int          ridx;
    logic        do_push;
    logic        do_pop;
    logic [63:0] l;
    logic [63:0] h;
    logic        sym;
    sz   = rowq.size();
    cnt  = (sz + 3) / 4;
    ridx = (4 - (sz % 4)) % 4;
    checks++;
    if (in_ready !== (cnt < DEPTH)) begin
      failures++;
      $display("FAIL in_ready: got %b want %b (t=%0t)", in_ready, cnt < DEPTH, $time);
    end
    checks++;
    if (out_valid !== (cnt != 0)) begin
      failures++;
      $display("FAIL out_valid: got %b want %b (t=%0t)", out_valid, cnt != 0, $time);
    end
    if (cnt != 0) begin
      checks++;
      if (out_row !== rowq[0]) begin
        failures++;
        $display("FAIL out_row: got %h want %h (t=%0t)", out_row, rowq[0], $time);
      end
      checks++;
      if (out_row_idx !== 2'(ridx) || out_last !== (ridx == 3)) begin
        failures++;
        $display("FAIL row_idx/last: got %0d/%b want %0d/%b (t=%0t)",
                 out_row_idx, out_last, ridx, ridx == 3, $time);
      end
    end
    do_push = in_valid && (cnt < DEPTH);
    do_pop  = out_ready && (cnt != 0);
    l = dsp_grp_l_in;
    h = dsp_grp_h_in;
    sym = super_y_symmetric;
    @(posedge clk);
    #1;
    if (do_pop) void'(rowq.pop_front());
    if (do_push) for (int r = 0; r < 4; r++) rowq.push_back(exp_row(l, h, sym, r));
  endtask

  task automatic drain();
    int budget;
    in_valid = 1'b0;
    out_ready = 1'b1;
    budget = 100;
    while (rowq.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (rowq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d rows left, want 0", rowq.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_row !== 32'h0 ||
        out_row_idx !== 2'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL %s: got rdy=%b vld=%b row=%h idx=%0d last=%b want 1 0 00000000 0 0",
               tag, in_ready, out_valid, out_row, out_row_idx, out_last);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_asserted");
    aresetn = 1'b1;
    rowq.delete();
    repeat (2) step();
    check_reset_outputs("reset_idle");
  endtask

  task automatic push_fixed(input logic sym, input logic [31:0] want [4]);
    dsp_grp_l_in = 64'h0706050403020100;
    dsp_grp_h_in = 64'h0F0E0D0C0B0A0908;
    super_y_symmetric = sym;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== want[r] || out_row_idx !== 2'(r) ||
          out_last !== (r == 3)) begin
        failures++;
        $display("FAIL fixed_sym%0d_row%0d: got vld=%b row=%h idx=%0d last=%b want row %h",
                 sym, r, out_valid, out_row, out_row_idx, out_last, want[r]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_normal_order();
    logic [31:0] want [4];
    want = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    push_fixed(1'b0, want);
  endtask

  task automatic test_mirrored();
    logic [31:0] want [4];
    want = '{32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
    push_fixed(1'b1, want);
  endtask

  task automatic test_backpressure();
    logic [31:0] first_row;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      dsp_grp_l_in = {$urandom, $urandom};
      dsp_grp_h_in = {$urandom, $urandom};
      super_y_symmetric = 1'($urandom);
      step();
      if (b == 0) first_row = rowq[0];
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_row !== first_row || out_row_idx !== 2'd0) begin
        failures++;
        $display("FAIL backpressure_hold: got rdy=%b row=%h idx=%0d want 0 %h 0",
                 in_ready, out_row, out_row_idx, first_row);
      end
      step();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int pops_last;
    pops_last = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      dsp_grp_l_in = {$urandom, $urandom};
      dsp_grp_h_in = {$urandom, $urandom};
      super_y_symmetric = 1'($urandom);
      if (out_valid && out_last) pops_last++;
      step();
    end
    checks++;
    if (pops_last < 11) begin
      failures++;
      $display("FAIL throughput: got %0d superblocks in 48 cycles want >= 11", pops_last);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      dsp_grp_l_in = {$urandom, $urandom};
      dsp_grp_h_in = {$urandom, $urandom};
      super_y_symmetric = 1'($urandom);
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    dsp_grp_l_in = {$urandom, $urandom};
    dsp_grp_h_in = {$urandom, $urandom};
    super_y_symmetric = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    aresetn = 1'b0;
    #1;
    rowq.delete();
    check_reset_outputs("reset_mid");
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_release");
    dsp_grp_l_in = 64'h1716151413121110;
    dsp_grp_h_in = 64'h1F1E1D1C1B1A1918;
    super_y_symmetric = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_row_idx !== 2'd0 || out_row !== 32'h1F1E1D1C) begin
      failures++;
      $display("FAIL reset_mid_next: got vld=%b idx=%0d row=%h want 1 0 1f1e1d1c",
               out_valid, out_row_idx, out_row);
    end
    drain();
  endtask

`ifdef BICUBIC_DEMUX_CLKEN_EN
  task automatic test_clken();
    dsp_grp_l_in = {$urandom, $urandom};
    dsp_grp_h_in = {$urandom, $urandom};
    super_y_symmetric = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_row_idx !== 2'd1 ||
          out_row !== rowq[0]) begin
        failures++;
        $display("FAIL clken_freeze: got rdy=%b vld=%b idx=%0d row=%h want 0 0 1 %h",
                 in_ready, out_valid, out_row_idx, out_row, rowq[0]);
      end
      @(posedge clk);
      #1;
    end
    clken = 1'b1;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_normal_order();
    test_mirrored();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef BICUBIC_DEMUX_CLKEN_EN
    test_clken();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
